mmio_uart_rx: RTL and testbench
===============================

MMIO_UART_RX -- requirements
Module: mmio_uart_rx

Interface
REQ-001 Parameter DEFAULT_DIV, 104, reset value of the clocks-per-bit divisor.
REQ-002 Parameter FIFO_DEPTH, 16, receive FIFO entries; power of two, 2..256.
REQ-003 Port clk  input  1  system clock; all logic on the rising edge.
REQ-004 Port resetn  input  1  reset; synchronous, active-low.
REQ-005 Port valid  input  1  CPU bus request to this block; address decode is done outside the block.
REQ-006 Port ready  output  1  one-cycle completion pulse for the request.
REQ-007 Port wstrb  input  4  byte write enables; 0 means read.
REQ-008 Port addr  input  32  byte address; only addr[3:2] decoded.
REQ-009 Port wdata  input  32  write data.
REQ-010 Port rdata  output  32  read data, valid while ready=1.
REQ-011 Port rx  input  1  asynchronous serial line, idle high.
REQ-012 Port irq  output  1  level interrupt request.

Function
REQ-013 Register map, by addr[3:2]: 0 DATA (RO, read pops the FIFO), 1 STATUS, 2 DIV (RW, 16 bits), 3 IRQ_EN (RW, 4 bits).
REQ-014 STATUS bits: [0] not_empty, [1] full, [2] overrun (sticky), [3] frame_err (sticky), [15:8] FIFO count; writing 1 to bit 2 or 3 clears that bit; all other bits are read-only.
REQ-015 Bus handshake: ready rises exactly one cycle after valid is first sampled high, stays high one cycle, then stays low for at least one cycle even if valid remains high.
REQ-016 Writes take effect on the ready cycle; only bytes with wstrb set are written; a write to DATA has no effect.
REQ-017 A read of DATA when the FIFO is non-empty returns {24'b0, head byte} and pops exactly once per transaction.
REQ-018 A read of DATA when the FIFO is empty returns 0 and does not pop.
REQ-019 rdata is 0 whenever ready is 0.
REQ-020 rx passes through a two-flop synchronizer; all receiver logic uses the synchronized value.
REQ-021 Receiver FSM states: IDLE, START, DATA, STOP.
REQ-022 IDLE -> START on a synchronized falling edge; the current DIV is latched for the whole frame.
REQ-023 START: after latched_div/2 cycles, a sampled low goes to DATA; a sampled high (glitch) returns to IDLE with no error.
REQ-024 DATA: samples 8 bits, LSB first, one every latched_div cycles, then goes to STOP.
REQ-025 STOP: samples after latched_div cycles. A high sample pushes the byte. A low sample sets frame_err, discards the byte, and waits in STOP until the line is high, then returns to IDLE.
REQ-026 A push when the FIFO is full sets overrun and drops the new byte; FIFO contents are unchanged.
REQ-027 A push and a pop in the same cycle both complete; the count is unchanged, including when the FIFO is full.
REQ-028 FIFO pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
REQ-029 A DIV write below 2 stores 2; a DIV write mid-frame applies from the next frame only.
REQ-030 irq = |(STATUS[3:0] & IRQ_EN), registered, asserted one cycle after the cause.

Reset
REQ-031 While resetn=0 at a clock edge: ready=0, rdata=0, irq=0, FSM=IDLE, FIFO empty, pointers=0, overrun=0, frame_err=0, DIV=DEFAULT_DIV, IRQ_EN=0, synchronizer flops=1.
REQ-032 Reset mid-frame discards the partial byte; any bus request pending during reset receives no ready.

Verification
REQ-033 DIV=16, send 0xA5 with a valid stop bit -> STATUS=0x0101; DATA read returns 0x000000A5; next STATUS=0x0000.
REQ-034 Send 17 bytes with FIFO_DEPTH=16 and no reads -> STATUS bits [1] and [2] set, count=16; 16 reads return the first 16 bytes in order; write 0x4 to STATUS clears overrun.
REQ-035 Send 0x3C with stop bit low -> frame_err=1, count=0; IRQ_EN=0x8 -> irq=1 one cycle later; write 0x8 to STATUS -> irq=0.
REQ-036 rx low pulse of 4 cycles with DIV=16 -> FSM returns to IDLE, STATUS=0, no push.
REQ-037 Hold valid high with wstrb=0 on DATA for 5 cycles -> ready pulses at cycle 2 and at cycle 4 at the earliest; each pulse pops exactly one byte; empty FIFO -> rdata=0.
REQ-038 Write DIV=1 -> DIV reads back 2; assert resetn=0 mid-frame -> all registers equal the REQ-031 values on the next cycle.

Source files
------------

// File: rtl/mmio_uart_rx_if.sv
// CPU bus bundle for the UART receiver register block.
interface mmio_uart_rx_if;
   logic        valid;
   logic        ready;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output valid, wstrb, addr, wdata, input ready, rdata);
   modport slave  (input valid, wstrb, addr, wdata, output ready, rdata);
endinterface

// File: rtl/mmio_uart_rx.sv
// Memory-mapped UART receiver: 2-flop rx synchronizer, 8N1 receive FSM,
// byte FIFO and a 4-register CPU bus slave with a level interrupt.
module mmio_uart_rx #(
   parameter int DEFAULT_DIV = 104,
   parameter int FIFO_DEPTH  = 16
) (
   input  logic           clk,
   input  logic           resetn,
   mmio_uart_rx_if.slave  bus,
   input  logic           rx,
   output logic           irq
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} rx_state_t;

   // Bus / register state
   logic [15:0]   div;
   logic [3:0]    irq_en;
   logic          overrun, frame_err;

   // FIFO state
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [CW-1:0] count;
   logic          empty, full;

   // Receiver state
   logic          rx_s1, rx_s2, rx_prev;
   rx_state_t     state, state_n;
   logic [15:0]   cnt, lat_div, tgt;
   logic [2:0]    bitn;
   logic [7:0]    sr;
   logic          stop_bad, tick, push, ferr;

   // Bus decode: a request is accepted on the cycle ready is about to rise
   logic          req, rd, wr, pop, push_ok, ovf;
   logic [1:0]    sel;
   logic [31:0]   status_w;
   logic          unused_ok;

   assign sel      = bus.addr[3:2];
   assign req      = bus.valid && !bus.ready;
   assign rd       = req && (bus.wstrb == 4'b0);
   assign wr       = req && (bus.wstrb != 4'b0);
   assign empty    = (count == '0);
   assign full     = (count == CW'(FIFO_DEPTH));
   assign pop      = rd && (sel == 2'd0) && !empty;
   // A push into a full FIFO still lands if a pop frees the slot this cycle
   assign push_ok  = push && (!full || pop);
   assign ovf      = push && full && !pop;
   assign status_w = {16'b0, 8'(count), 4'b0, frame_err, overrun, full, !empty};
   assign unused_ok = ^{bus.addr[31:4], bus.addr[1:0], bus.wdata[31:16]};

   // Two-flop synchronizer plus one delay stage for falling-edge detection
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_s1   <= rx;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
      end
   end

   // Receiver state register
   always_ff @(posedge clk) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_n;
   end

   // Receiver next-state and strobes; START waits half a bit to hit mid-bit
   always_comb begin
      state_n = state;
      push    = 1'b0;
      ferr    = 1'b0;
      tgt     = (state == S_START) ? {1'b0, lat_div[15:1]} : lat_div;
      tick    = (cnt == tgt - 16'd1);
      case (state)
         S_IDLE:  if (rx_prev && !rx_s2) state_n = S_START;
         S_START: if (tick) state_n = rx_s2 ? S_IDLE : S_DATA;
         S_DATA:  if (tick && bitn == 3'd7) state_n = S_STOP;
         S_STOP: begin
            if (stop_bad) begin
               if (rx_s2) state_n = S_IDLE;
            end else if (tick) begin
               if (rx_s2) begin
                  push    = 1'b1;
                  state_n = S_IDLE;
               end else begin
                  ferr    = 1'b1;
               end
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Receiver datapath; DIV is tracked while idle so it is frozen per frame
   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt      <= '0;
         bitn     <= '0;
         sr       <= '0;
         stop_bad <= 1'b0;
         lat_div  <= 16'(DEFAULT_DIV);
      end else if (state == S_IDLE) begin
         cnt      <= '0;
         bitn     <= '0;
         stop_bad <= 1'b0;
         lat_div  <= div;
      end else begin
         cnt <= tick ? 16'd0 : cnt + 16'd1;
         if (state == S_DATA && tick) begin
            sr   <= {rx_s2, sr[7:1]};
            bitn <= bitn + 3'd1;
         end
         if (ferr) stop_bad <= 1'b1;
      end
   end

   // Receive FIFO: pointers wrap naturally at the power-of-two depth
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push_ok) begin
            mem[wptr] <= sr;
            wptr      <= wptr + 1'b1;
         end
         if (pop) rptr <= rptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Bus handshake, register file, sticky status and registered irq
   always_ff @(posedge clk) begin
      if (!resetn) begin
         bus.ready <= 1'b0;
         bus.rdata <= '0;
         div       <= 16'(DEFAULT_DIV);
         irq_en    <= '0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
         irq       <= 1'b0;
      end else begin
         bus.ready <= req;
         bus.rdata <= '0;
         irq       <= |({frame_err, overrun, full, !empty} & irq_en);
         if (rd) begin
            case (sel)
               2'd0:    bus.rdata <= empty ? 32'b0 : {24'b0, mem[rptr]};
               2'd1:    bus.rdata <= status_w;
               2'd2:    bus.rdata <= {16'b0, div};
               default: bus.rdata <= {28'b0, irq_en};
            endcase
         end
         if (wr) begin
            case (sel)
               2'd1: if (bus.wstrb[0]) begin
                  if (bus.wdata[2]) overrun   <= 1'b0;
                  if (bus.wdata[3]) frame_err <= 1'b0;
               end
               2'd2: begin : div_wr
                  logic [15:0] dm;
                  dm[7:0]  = bus.wstrb[0] ? bus.wdata[7:0]  : div[7:0];
                  dm[15:8] = bus.wstrb[1] ? bus.wdata[15:8] : div[15:8];
                  div <= (dm < 16'd2) ? 16'd2 : dm;
               end
               2'd3: if (bus.wstrb[0]) irq_en <= bus.wdata[3:0];
               default: ;
            endcase
         end
         // New receive events win over a same-cycle clear
         if (ovf)  overrun   <= 1'b1;
         if (ferr) frame_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_mmio_uart_rx.sv
// Directed bench for mmio_uart_rx: register access, framing, FIFO and reset.
module tb_mmio_uart_rx;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic rx = 1'b1;
   logic irq;
   int   checks = 0;
   int   errors = 0;

   mmio_uart_rx_if bus();

   mmio_uart_rx #(.DEFAULT_DIV(104), .FIFO_DEPTH(16)) dut (
      .clk(clk), .resetn(resetn), .bus(bus), .rx(rx), .irq(irq)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic hold(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic xfer(input logic [3:0] ws, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] r);
      bit got = 1'b0;
      @(posedge clk); #1;
      bus.valid = 1'b1; bus.wstrb = ws; bus.addr = a; bus.wdata = d;
      r = '0;
      for (int i = 0; i < 8 && !got; i++) begin
         @(posedge clk); #1;
         if (bus.ready) begin got = 1'b1; r = bus.rdata; end
      end
      bus.valid = 1'b0; bus.wstrb = '0;
      checks++;
      if (!got) begin errors++; $display("FAIL xfer_timeout addr=%h no ready", a); end
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] r);
      xfer(4'h0, a, 32'h0, r);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      logic [31:0] dummy;
      xfer(4'hF, a, d, dummy);
   endtask

   task automatic send(input logic [7:0] b, input bit stop_ok, input int div);
      @(posedge clk); #1;
      rx = 1'b0; hold(div);
      for (int i = 0; i < 8; i++) begin rx = b[i]; hold(div); end
      rx = stop_ok; hold(div);
      rx = 1'b1; hold(2 * div);
   endtask

   task automatic test_reset();
      logic [31:0] r;
      hold(3);
      checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", bus.ready); end
      checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", bus.rdata); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", irq); end
      resetn = 1'b1; hold(2);
      rd(32'h4, r);  checks++; if (r !== 32'h0)  begin errors++; $display("FAIL rst_status got %h exp 0", r); end
      rd(32'h8, r);  checks++; if (r !== 32'h68) begin errors++; $display("FAIL rst_div got %h exp 68", r); end
      rd(32'hC, r);  checks++; if (r !== 32'h0)  begin errors++; $display("FAIL rst_irqen got %h exp 0", r); end
      rd(32'h0, r);  checks++; if (r !== 32'h0)  begin errors++; $display("FAIL rst_data got %h exp 0", r); end
   endtask

   task automatic test_basic();
      logic [31:0] r;
      wr(32'h8, 32'd16);
      send(8'hA5, 1'b1, 16);
      rd(32'h4, r); checks++; if (r !== 32'h0101) begin errors++; $display("FAIL basic_status got %h exp 0101", r); end
      rd(32'h0, r); checks++; if (r !== 32'hA5)   begin errors++; $display("FAIL basic_data got %h exp a5", r); end
      rd(32'h4, r); checks++; if (r !== 32'h0)    begin errors++; $display("FAIL basic_status2 got %h exp 0", r); end
   endtask

   task automatic test_div();
      logic [31:0] r;
      wr(32'h8, 32'd1);
      rd(32'h8, r); checks++; if (r !== 32'h2) begin errors++; $display("FAIL div_min got %h exp 2", r); end
      xfer(4'b0001, 32'h8, 32'h1234_5630, r);
      rd(32'h8, r); checks++; if (r !== 32'h30) begin errors++; $display("FAIL div_strobe got %h exp 30", r); end
      wr(32'h0, 32'h0000_00FF);
      rd(32'h4, r); checks++; if (r !== 32'h0) begin errors++; $display("FAIL data_write got %h exp 0", r); end
      wr(32'h8, 32'd16);
      rd(32'h8, r); checks++; if (r !== 32'h10) begin errors++; $display("FAIL div_16 got %h exp 10", r); end
   endtask

   task automatic test_glitch();
      logic [31:0] r;
      @(posedge clk); #1;
      rx = 1'b0; hold(4);
      rx = 1'b1; hold(40);
      rd(32'h4, r); checks++; if (r !== 32'h0) begin errors++; $display("FAIL glitch_status got %h exp 0", r); end
      send(8'h5A, 1'b1, 16);
      rd(32'h0, r); checks++; if (r !== 32'h5A) begin errors++; $display("FAIL glitch_recover got %h exp 5a", r); end
   endtask

   task automatic test_frame();
      logic [31:0] r;
      send(8'h3C, 1'b0, 16);
      rd(32'h4, r); checks++; if (r !== 32'h0008) begin errors++; $display("FAIL frame_status got %h exp 0008", r); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL frame_irq_off got %b exp 0", irq); end
      wr(32'hC, 32'h8); hold(1);
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL frame_irq_on got %b exp 1", irq); end
      wr(32'h4, 32'h8); hold(1);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL frame_irq_clr got %b exp 0", irq); end
      rd(32'h4, r); checks++; if (r !== 32'h0) begin errors++; $display("FAIL frame_status2 got %h exp 0", r); end
      wr(32'hC, 32'h0);
   endtask

   task automatic test_overrun();
      logic [31:0] r;
      for (int i = 0; i < 17; i++) send(8'h40 + 8'(i), 1'b1, 16);
      rd(32'h4, r); checks++; if (r !== 32'h1007) begin errors++; $display("FAIL ovr_status got %h exp 1007", r); end
      for (int i = 0; i < 16; i++) begin
         rd(32'h0, r);
         checks++;
         if (r !== 32'h40 + 32'(i)) begin errors++; $display("FAIL ovr_data%0d got %h exp %h", i, r, 32'h40 + 32'(i)); end
      end
      rd(32'h4, r); checks++; if (r !== 32'h0004) begin errors++; $display("FAIL ovr_sticky got %h exp 0004", r); end
      wr(32'h4, 32'h4);
      rd(32'h4, r); checks++; if (r !== 32'h0) begin errors++; $display("FAIL ovr_clear got %h exp 0", r); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] r;
      logic [31:0] exp_d [5] = '{32'h11, 32'h0, 32'h22, 32'h0, 32'h0};
      send(8'h11, 1'b1, 16);
      send(8'h22, 1'b1, 16);
      @(posedge clk); #1;
      bus.valid = 1'b1; bus.wstrb = 4'h0; bus.addr = 32'h0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if (bus.ready !== ((i % 2) == 0)) begin errors++; $display("FAIL b2b_ready%0d got %b exp %b", i, bus.ready, (i % 2) == 0); end
         checks++;
         if (bus.rdata !== exp_d[i]) begin errors++; $display("FAIL b2b_rdata%0d got %h exp %h", i, bus.rdata, exp_d[i]); end
      end
      bus.valid = 1'b0;
      hold(1);
      checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b exp 0", bus.ready); end
      rd(32'h4, r); checks++; if (r !== 32'h0) begin errors++; $display("FAIL b2b_status got %h exp 0", r); end
   endtask

   task automatic test_reset_midframe();
      logic [31:0] r;
      wr(32'hC, 32'h1);
      send(8'h77, 1'b1, 16);
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL mid_irq_pre got %b exp 1", irq); end
      wr(32'h8, 32'd20);
      @(posedge clk); #1;
      rx = 1'b0; hold(30);
      bus.valid = 1'b1; bus.wstrb = 4'h0; bus.addr = 32'h4;
      resetn = 1'b0;
      hold(1);
      checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL mid_ready got %b exp 0", bus.ready); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_irq got %b exp 0", irq); end
      rx = 1'b1; hold(1);
      checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL mid_ready2 got %b exp 0", bus.ready); end
      bus.valid = 1'b0;
      resetn = 1'b1;
      hold(1);
      rd(32'h4, r); checks++; if (r !== 32'h0)  begin errors++; $display("FAIL mid_status got %h exp 0", r); end
      rd(32'h8, r); checks++; if (r !== 32'h68) begin errors++; $display("FAIL mid_div got %h exp 68", r); end
      rd(32'hC, r); checks++; if (r !== 32'h0)  begin errors++; $display("FAIL mid_irqen got %h exp 0", r); end
      rd(32'h0, r); checks++; if (r !== 32'h0)  begin errors++; $display("FAIL mid_data got %h exp 0", r); end
      hold(300);
      rd(32'h4, r); checks++; if (r !== 32'h0)  begin errors++; $display("FAIL mid_quiet got %h exp 0", r); end
   endtask

   initial begin
      bus.valid = 1'b0; bus.wstrb = 4'h0; bus.addr = 32'h0; bus.wdata = 32'h0;
      test_reset();
      test_basic();
      test_div();
      test_glitch();
      test_frame();
      test_overrun();
      test_back_to_back();
      test_reset_midframe();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
